// File: rtl/sha1_iter_core.sv
// sha1_iter_core: iterative SHA-1 compression of one 512-bit block, ROUNDS_PER_CYCLE rounds per clock.
// Define SHA1_MIDSTATE_EN to add the h_in/load_mid mid-state load port.
module sha1_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         next,
    input  logic [511:0] block,
`ifdef SHA1_MIDSTATE_EN
    input  logic [159:0] h_in,
    input  logic         load_mid,
`endif
    output logic         ready,
    output logic [159:0] digest,
    output logic         digest_valid
);

    localparam logic [159:0] SHA1_IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [6:0]   T_STEP  = 7'(ROUNDS_PER_CYCLE);
    localparam logic [6:0]   T_LAST  = 7'(80 - ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUNDS = 2'd1,
        ST_FINAL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              ready_r;
    logic              dv_r;
    logic [159:0]      h_r;
    logic [6:0]        t_r;
    logic [31:0]       a_r, b_r, c_r, d_r, e_r;
    logic [15:0][31:0] w_r;
    logic [15:0][31:0] w_nxt_s;
    logic [31:0]       ra_s, rb_s, rc_s, rd_s, re_s;
    logic              accept_s;
    logic              last_grp_s;
    logic [159:0]      chain_s;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rotl30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    function automatic logic [31:0] f_fn(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        logic [31:0] f;
        if (t < 7'd20) begin
            f = (b & c) | (~b & d);
        end else if (t < 7'd40) begin
            f = b ^ c ^ d;
        end else if (t < 7'd60) begin
            f = (b & c) | (b & d) | (c & d);
        end else begin
            f = b ^ c ^ d;
        end
        return f;
    endfunction

    function automatic logic [31:0] k_fn(input logic [6:0] t);
        logic [31:0] k;
        if (t < 7'd20) begin
            k = 32'h5a827999;
        end else if (t < 7'd40) begin
            k = 32'h6ed9eba1;
        end else if (t < 7'd60) begin
            k = 32'h8f1bbcdc;
        end else begin
            k = 32'hca62c1d6;
        end
        return k;
    endfunction

    // State register; ready is registered alongside so it tracks IDLE exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ROUNDS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ROUNDS: begin
                if (last_grp_s) begin
                    state_nxt_s = ST_FINAL;
                end else begin
                    state_nxt_s = ST_ROUNDS;
                end
            end
            ST_FINAL: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Control decode: command acceptance, end of round groups, chaining source
    always_comb begin
        accept_s   = (init | next) & ready_r;
        last_grp_s = (state_r == ST_ROUNDS) && (t_r == T_LAST);
        if (init) begin
            chain_s = SHA1_IV;
        end else begin
            chain_s = h_r;
        end
    end

    // One unrolled group of rounds plus the window words it consumes
    always_comb begin
        logic [31:0] wx [16+ROUNDS_PER_CYCLE];
        logic [31:0] va, vb, vc, vd, ve, tv;
        logic [6:0]  tk;
        for (int i = 0; i < 16; i++) begin
            wx[i] = w_r[i];
        end
        // Window slot i holds W(t+i), so W(t+16+j) draws on slots 13,8,2,0 offset by j
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            wx[16+j] = rotl1(wx[13+j] ^ wx[8+j] ^ wx[2+j] ^ wx[j]);
        end
        va = a_r;
        vb = b_r;
        vc = c_r;
        vd = d_r;
        ve = e_r;
        tv = 32'd0;
        tk = t_r;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            tk = t_r + 7'(k);
            tv = rotl5(va) + f_fn(tk, vb, vc, vd) + ve + k_fn(tk) + wx[k];
            ve = vd;
            vd = vc;
            vc = rotl30(vb);
            vb = va;
            va = tv;
        end
        for (int i = 0; i < 16; i++) begin
            w_nxt_s[i] = wx[i+ROUNDS_PER_CYCLE];
        end
        ra_s = va;
        rb_s = vb;
        rc_s = vc;
        rd_s = vd;
        re_s = ve;
    end

    // Datapath: block capture, working variables, round counter, chaining value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_r  <= '0;
            a_r  <= 32'd0;
            b_r  <= 32'd0;
            c_r  <= 32'd0;
            d_r  <= 32'd0;
            e_r  <= 32'd0;
            t_r  <= 7'd0;
            h_r  <= SHA1_IV;
            dv_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        for (int i = 0; i < 16; i++) begin
                            w_r[i] <= block[511-32*i -: 32];
                        end
                        a_r  <= chain_s[159:128];
                        b_r  <= chain_s[127:96];
                        c_r  <= chain_s[95:64];
                        d_r  <= chain_s[63:32];
                        e_r  <= chain_s[31:0];
                        t_r  <= 7'd0;
                        h_r  <= chain_s;
                        dv_r <= 1'b0;
`ifdef SHA1_MIDSTATE_EN
                    end else if (load_mid & ready_r) begin
                        h_r  <= h_in;
                        dv_r <= 1'b0;
`endif
                    end else begin
                        h_r <= h_r;
                    end
                end
                ST_ROUNDS: begin
                    w_r <= w_nxt_s;
                    a_r <= ra_s;
                    b_r <= rb_s;
                    c_r <= rc_s;
                    d_r <= rd_s;
                    e_r <= re_s;
                    t_r <= t_r + T_STEP;
                end
                ST_FINAL: begin
                    h_r  <= {h_r[159:128] + a_r, h_r[127:96] + b_r, h_r[95:64] + c_r,
                             h_r[63:32] + d_r, h_r[31:0] + e_r};
                    dv_r <= 1'b1;
                end
                default: begin
                    dv_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready        = ready_r;
    assign digest       = h_r;
    assign digest_valid = dv_r;

endmodule

// File: doc/sha1_iter_core.md
SHA1_ITER_CORE -- requirements
Module: sha1_iter_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1: number of SHA-1 rounds evaluated per clock; legal values are 1, 2, 4 and 5.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port init, input, 1 bit: start the first block of a message, with H loaded from the standard IV.
REQ-005 SHALL have port next, input, 1 bit: start a chained block, with H taken from the current digest.
REQ-006 SHALL have port block, input, 512 bits: message block; word W0 = block[511:480] and W15 = block[31:0].
REQ-007 SHALL have port ready, output, 1 bit: core idle and able to accept init or next.
REQ-008 SHALL have port digest, output, 160 bits: {H0,H1,H2,H3,H4}, with H0 in bits [159:128].
REQ-009 SHALL have port digest_valid, output, 1 bit: digest holds the result of the last accepted block.

Function
REQ-010 SHALL implement the state machine IDLE -> ROUNDS -> FINAL -> IDLE; ready=1 only in IDLE.
REQ-011 SHALL accept a command only when (init|next) & ready on a clock edge; commands while not ready are ignored with no side effect.
REQ-012 SHALL give init priority over next when both are asserted on the same edge.
REQ-013 On accept, SHALL capture block into a 16x32 W window, load a..e from the chaining value (IV on init, H on next), clear the round counter t, clear digest_valid and enter ROUNDS.
REQ-014 In ROUNDS, SHALL perform ROUNDS_PER_CYCLE rounds per cycle, with t advancing by ROUNDS_PER_CYCLE per cycle.
REQ-015 Each round SHALL compute T = ROTL5(a) + f_t(b,c,d) + e + K_t + W_t (mod 2^32), then e=d, d=c, c=ROTL30(b), b=a, a=T; rotations SHALL be circular, never shifts.
REQ-016 SHALL use these f/K values:
- t 0..19: f=(b&c)|(~b&d), K=5A827999.
- t 20..39: f=b^c^d, K=6ED9EBA1.
- t 40..59: f=(b&c)|(b&d)|(c&d), K=8F1BBCDC.
- t 60..79: f=b^c^d, K=CA62C1D6.
- Selection SHALL be per individual round inside an unrolled group.
REQ-017 For t>=16, SHALL form W_t = ROTL1(W_t-3 ^ W_t-8 ^ W_t-14 ^ W_t-16) in the sliding window; no 80-entry array.
REQ-018 SHALL leave ROUNDS for FINAL when the group containing t=79 completes.
REQ-019 In FINAL, SHALL set Hi = Hi_chain + working var (mod 2^32), assert digest_valid and return to IDLE.
REQ-020 Latency: digest_valid SHALL rise 80/ROUNDS_PER_CYCLE+1 cycles after the accepting edge (81 for R=1, 21 for R=4).
REQ-021 digest SHALL be stable while digest_valid=1 and SHALL remain stable until the next accept.
REQ-022 digest_valid SHALL stay asserted until the next accepted command.
REQ-023 block SHALL be sampled only at accept; later changes to block SHALL NOT affect the result.

Reset
REQ-024 On rst, SHALL set state=IDLE, ready=1, digest_valid=0, t=0, and H/digest = 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0.
REQ-025 A rst mid-operation SHALL abort the block immediately; the next accept SHALL start cleanly.
REQ-026 next after reset without a prior init SHALL behave identically to init.

Configuration
REQ-027 With macro SHA1_MIDSTATE_EN defined, SHALL add inputs h_in[159:0] and load_mid; load_mid&ready SHALL write h_in into H with digest_valid=0, and load_mid SHALL have the lowest priority after init and next.
REQ-028 With SHA1_MIDSTATE_EN undefined, these ports and this logic SHALL be absent and H SHALL be writable only by reset and FINAL.

Verification
REQ-029 R=1, init with padded "abc" (616263 80..00 ...18) -> digest A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D, with digest_valid at edge 81.
REQ-030 R=4, init then next with the two padded blocks of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> 84983E44 1C3BD26E BAAE4AA1 F95129E5 E54670F1, with 21 cycles per block.
REQ-031 init pulsed at cycle 10 of a block -> ignored, and the result equals the undisturbed run.
REQ-032 rst asserted at round 40, then init "abc" -> ready=1 and digest=IV during reset, followed by the correct "abc" digest.
REQ-033 init and next on the same edge after a prior digest -> IV chaining used, giving the "abc" digest.
REQ-034 SHA1_MIDSTATE_EN defined: load_mid with the first-block digest of REQ-030, then next with block 2 -> 84983E44 ... E54670F1.
